multi_port_ram: RTL and testbench

Parametrised register-file RAM with one write port and `NUM_RD` independent read ports. Each read port has its own enable, registered output and valid flag, and read/write collisions resolve under a configurable ordering rule. A built-in clear sequencer zeroes the whole array after reset or on request. It serves as the general line/character buffer for the LCD datapath, where several consumers sample the same store in parallel.

---
 rtl/multi_port_ram_pkg.sv | 8 +
 rtl/ram_read_port.sv | 54 +++++
 rtl/multi_port_ram.sv | 112 +++++++++++
 tb/tb_multi_port_ram.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_port_ram_pkg.sv
// rtl/multi_port_ram_pkg.sv - shared types and limits for the multi-port register-file RAM
package multi_port_ram_pkg;

  typedef enum logic {ST_INIT, ST_RUN} ram_state_t;

  localparam int MAX_RD = 8;

endpackage

// File: rtl/ram_read_port.sv
// rtl/ram_read_port.sv - one registered read port with accept logic and collision ordering
module ram_read_port
  import multi_port_ram_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int WRITE_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  ram_state_t        state,
  input  logic              ce,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr_r,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [DATA_W-1:0] data_w,
  output logic [DATA_W-1:0] data_r,
  output logic              rd_valid
);

  logic              accept;
  logic [DATA_W-1:0] rd_sel;
  logic [DATA_W-1:0] data_r_d, data_r_q;
  logic              rd_valid_d, rd_valid_q;

  // A clear request in the same cycle wins over any read.
  assign accept = (state == ST_RUN) && ce && !clr && rd_en;

  always_comb begin
    rd_sel = mem_rdata;
    if ((WRITE_FIRST != 0) && wr_en && (addr_w == addr_r)) begin
      rd_sel = data_w;
    end
    data_r_d   = accept ? rd_sel : data_r_q;
    rd_valid_d = accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_r_q   <= data_r_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_r   = data_r_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/multi_port_ram.sv
// rtl/multi_port_ram.sv - single-write, NUM_RD-read register-file RAM with clear sequencer
module multi_port_ram
  import multi_port_ram_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int NUM_RD      = 3,
  parameter int WRITE_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     clr,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr_w,
  input  logic [DATA_W-1:0]        data_w,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] addr_r,
  output logic [NUM_RD*DATA_W-1:0] data_r,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_num_rd
    $error("multi_port_ram: NUM_RD out of range");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  ram_state_t        state_d, state_q;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = addr_w;
    mem_wdata = data_w;
    wr_en     = 1'b0;
    case (state_q)
      ST_INIT: begin
        // The sweep ignores ce; a clr here simply restarts it from address 0.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (clr) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (&cnt_q) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ce && clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (ce && we) begin
          mem_we = 1'b1;
          wr_en  = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign init_busy = (state_q == ST_INIT);

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    ram_read_port #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .WRITE_FIRST(WRITE_FIRST)
    ) u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .state    (state_q),
      .ce       (ce),
      .clr      (clr),
      .rd_en    (rd_en[g]),
      .addr_r   (addr_r[g*ADDR_W +: ADDR_W]),
      .mem_rdata(mem_q[addr_r[g*ADDR_W +: ADDR_W]]),
      .wr_en    (wr_en),
      .addr_w   (addr_w),
      .data_w   (data_w),
      .data_r   (data_r[g*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[g])
    );
  end

endmodule

// File: tb/tb_multi_port_ram.sv
// tb/tb_multi_port_ram.sv - bench for multi_port_ram, read-old and read-new variants side by side
module tb_multi_port_ram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 3;
  localparam int DEPTH  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     ce, clr, we;
  logic [ADDR_W-1:0]        addr_w;
  logic [DATA_W-1:0]        data_w;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] addr_r;
  logic [NUM_RD*DATA_W-1:0] data_r0, data_r1;
  logic [NUM_RD-1:0]        rd_valid0, rd_valid1;
  logic                     init_busy0, init_busy1;

  int checks = 0;
  int errors = 0;

  // Reference state: word array, sweep bookkeeping, expected port outputs.
  int                mem_m [DEPTH];
  bit                busy_m;
  int                sweep_left;
  logic [DATA_W-1:0] exp0 [NUM_RD];
  logic [DATA_W-1:0] exp1 [NUM_RD];
  logic [NUM_RD-1:0] expv;

  multi_port_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .WRITE_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .we(we), .addr_w(addr_w), .data_w(data_w),
    .rd_en(rd_en), .addr_r(addr_r), .data_r(data_r0), .rd_valid(rd_valid0), .init_busy(init_busy0)
  );

  multi_port_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .WRITE_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .we(we), .addr_w(addr_w), .data_w(data_w),
    .rd_en(rd_en), .addr_r(addr_r), .data_r(data_r1), .rd_valid(rd_valid1), .init_busy(init_busy1)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    ce = 1'b0; clr = 1'b0; we = 1'b0; addr_w = '0; data_w = '0; rd_en = '0; addr_r = '0;
  endtask

  task automatic model_reset();
    busy_m = 1'b1;
    sweep_left = DEPTH;
    expv = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      exp0[i] = '0;
      exp1[i] = '0;
    end
  endtask

  task automatic model_step();
    int a;
    if (busy_m) begin
      expv = '0;
      if (clr) sweep_left = DEPTH;
      else begin
        sweep_left--;
        if (sweep_left == 0) begin
          busy_m = 1'b0;
          for (int k = 0; k < DEPTH; k++) mem_m[k] = 0;
        end
      end
    end else if (ce && clr) begin
      expv = '0;
      busy_m = 1'b1;
      sweep_left = DEPTH;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        a = int'(addr_r[i*ADDR_W +: ADDR_W]);
        if (ce && rd_en[i]) begin
          expv[i] = 1'b1;
          exp0[i] = DATA_W'(mem_m[a]);
          exp1[i] = (we && int'(addr_w) == a) ? data_w : DATA_W'(mem_m[a]);
        end else begin
          expv[i] = 1'b0;
        end
      end
      if (ce && we) mem_m[addr_w] = int'(data_w);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({init_busy0, init_busy1, rd_valid0, rd_valid1} !== {2'b11, 6'b0}) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b%b valid=%b/%b want busy=11 valid=0", init_busy0, init_busy1, rd_valid0, rd_valid1);
    end
    checks++;
    if ({data_r0, data_r1} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 0", data_r0, data_r1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (init_busy0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != DEPTH || init_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_sweep_len: got %0d busy cycles (busy1=%b) want %0d", n, init_busy1, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      ce = 1'b1; rd_en = '1;
      addr_r = {ADDR_W'((a + 11) % DEPTH), ADDR_W'((a + 5) % DEPTH), ADDR_W'(a)};
      tick();
      checks++;
      if ({data_r0, data_r1, rd_valid0, rd_valid1} !== {48'h0, 6'b111111}) begin
        errors++;
        $display("FAIL reset_zero_read a=%0d: got %h/%h valid %b/%b want 0 valid 111", a, data_r0, data_r1, rd_valid0, rd_valid1);
      end
    end
    set_idle();
  endtask

  task automatic test_write_read();
    ce = 1'b1; we = 1'b1; addr_w = 4'd3; data_w = 8'hA5;
    tick();
    we = 1'b0; rd_en = 3'b111; addr_r = {4'd7, 4'd3, 4'd3};
    tick();
    checks++;
    if (data_r0 !== 24'h00A5A5 || data_r1 !== 24'h00A5A5 || rd_valid0 !== 3'b111 || rd_valid1 !== 3'b111) begin
      errors++;
      $display("FAIL write_read: got %h/%h valid %b/%b want 00a5a5 valid 111", data_r0, data_r1, rd_valid0, rd_valid1);
    end
    set_idle();
  endtask

  task automatic test_collision();
    ce = 1'b1; we = 1'b1; addr_w = 4'd5; data_w = 8'h11;
    tick();
    data_w = 8'h3C; rd_en = 3'b010; addr_r = {4'd0, 4'd5, 4'd0};
    tick();
    checks++;
    if (data_r0[15:8] !== 8'h11 || rd_valid0 !== 3'b010) begin
      errors++;
      $display("FAIL collision_old: got %h valid %b want 11 valid 010", data_r0[15:8], rd_valid0);
    end
    checks++;
    if (data_r1[15:8] !== 8'h3C || rd_valid1 !== 3'b010) begin
      errors++;
      $display("FAIL collision_new: got %h valid %b want 3c valid 010", data_r1[15:8], rd_valid1);
    end
    we = 1'b0; rd_en = 3'b001; addr_r = {4'd0, 4'd0, 4'd5};
    tick();
    checks++;
    if (data_r0[7:0] !== 8'h3C || data_r1[7:0] !== 8'h3C) begin
      errors++;
      $display("FAIL collision_after: got %h/%h want 3c", data_r0[7:0], data_r1[7:0]);
    end
    set_idle();
  endtask

  task automatic test_hold();
    ce = 1'b1; we = 1'b1; addr_w = 4'd9; data_w = 8'h44;
    tick();
    we = 1'b0; rd_en = 3'b100; addr_r = {4'd9, 4'd0, 4'd0};
    tick();
    checks++;
    if (data_r0[23:16] !== 8'h44 || rd_valid0[2] !== 1'b1) begin
      errors++;
      $display("FAIL hold_read: got %h valid %b want 44 valid 1", data_r0[23:16], rd_valid0[2]);
    end
    we = 1'b1; data_w = 8'h55; rd_en = '0;
    tick();
    checks++;
    if (data_r0[23:16] !== 8'h44 || data_r1[23:16] !== 8'h44 || rd_valid0[2] !== 1'b0 || rd_valid1[2] !== 1'b0) begin
      errors++;
      $display("FAIL hold_keep: got %h/%h valid %b/%b want 44 valid 0", data_r0[23:16], data_r1[23:16], rd_valid0[2], rd_valid1[2]);
    end
    set_idle();
  endtask

  task automatic test_clr();
    int n;
    ce = 1'b1; clr = 1'b1; we = 1'b1; addr_w = 4'd2; data_w = 8'hFF; rd_en = 3'b111; addr_r = {4'd2, 4'd2, 4'd2};
    tick();
    clr = 1'b0;
    n = 0;
    while (init_busy0 && n < 40) begin
      checks++;
      if (rd_valid0 !== 3'b000 || rd_valid1 !== 3'b000) begin
        errors++;
        $display("FAIL clr_valid_low n=%0d: got %b/%b want 000", n, rd_valid0, rd_valid1);
      end
      tick();
      n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clr_sweep_len: got %0d want %0d", n, DEPTH);
    end
    set_idle();
    ce = 1'b1; rd_en = 3'b111; addr_r = {4'd2, 4'd2, 4'd2};
    tick();
    checks++;
    if (data_r0 !== 24'h0 || data_r1 !== 24'h0 || rd_valid0 !== 3'b111) begin
      errors++;
      $display("FAIL clr_dropped_write: got %h/%h valid %b want 0 valid 111", data_r0, data_r1, rd_valid0);
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ce     = ($urandom_range(0, 3) != 0);
      clr    = ($urandom_range(0, 60) == 0);
      we     = $urandom_range(0, 1);
      addr_w = ADDR_W'($urandom_range(0, 7));
      data_w = DATA_W'($urandom);
      rd_en  = NUM_RD'($urandom);
      for (int i = 0; i < NUM_RD; i++) addr_r[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
      tick();
      for (int i = 0; i < NUM_RD; i++) begin
        checks++;
        if (data_r0[i*DATA_W +: DATA_W] !== exp0[i] || data_r1[i*DATA_W +: DATA_W] !== exp1[i]) begin
          errors++;
          $display("FAIL rand_data c=%0d port=%0d: got %h/%h want %h/%h", c, i,
                   data_r0[i*DATA_W +: DATA_W], data_r1[i*DATA_W +: DATA_W], exp0[i], exp1[i]);
        end
      end
      checks++;
      if ({rd_valid0, rd_valid1, init_busy0, init_busy1} !== {expv, expv, busy_m, busy_m}) begin
        errors++;
        $display("FAIL rand_flags c=%0d: got valid %b/%b busy %b/%b want valid %b busy %b", c,
                 rd_valid0, rd_valid1, init_busy0, init_busy1, expv, busy_m);
      end
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (busy_m && n < 40) begin
      tick();
      n++;
    end
    ce = 1'b1; we = 1'b1; addr_w = 4'd1; data_w = 8'h77;
    tick();
    we = 1'b0; rd_en = 3'b111; addr_r = {4'd1, 4'd1, 4'd1};
    tick();
    checks++;
    if (data_r0 !== 24'h777777 || data_r1 !== 24'h777777) begin
      errors++;
      $display("FAIL arst_preload: got %h/%h want 777777", data_r0, data_r1);
    end
    rd_en = '0; clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({data_r0, data_r1, rd_valid0, rd_valid1} !== '0 || {init_busy0, init_busy1} !== 2'b11) begin
      errors++;
      $display("FAIL arst_immediate: got %h/%h valid %b/%b busy %b%b want 0 busy 11",
               data_r0, data_r1, rd_valid0, rd_valid1, init_busy0, init_busy1);
    end
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (init_busy0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != DEPTH || init_busy1 !== 1'b0) begin
      errors++;
      $display("FAIL arst_sweep_len: got %0d (busy1=%b) want %0d", n, init_busy1, DEPTH);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    for (int k = 0; k < DEPTH; k++) mem_m[k] = 0;
    model_reset();
    test_reset();
    test_write_read();
    test_collision();
    test_hold();
    test_clr();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
